// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: serialises read/write requests from two ports onto
// a single data-memory port through an IDLE -> ISSUE -> WAIT -> RESP FSM.
// Writes complete when mem_done_i toggles, or abort after TIMEOUT wait cycles
// (sticky err_o).
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration between
// simultaneous requests; without it port 0 has fixed priority.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic       we0_i,
    input  logic       we1_i,
    input  logic [3:0] addr0_i,
    input  logic [3:0] addr1_i,
    input  logic [7:0] wdata0_i,
    input  logic [7:0] wdata1_i,
    output logic       ack0_o,
    output logic       ack1_o,
    output logic [7:0] rdata0_o,
    output logic [7:0] rdata1_o,
    output logic [3:0] mem_addr_o,
    output logic       mem_r_o,
    output logic       mem_w_o,
    output logic [7:0] mem_in_o,
    input  logic [7:0] mem_out_i,
    input  logic       mem_done_i,
    output logic       busy_o,
    output logic       err_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    localparam logic [3:0] TIMEOUT_C = 4'(TIMEOUT);

    state_e     state_q;
    logic       gnt_q;      // port currently being served
    logic       we_q;
    logic       done_q;     // mem_done_i level captured at grant
    logic [3:0] cnt_q;      // write wait counter
    logic       ack0_q, ack1_q;
    logic [7:0] rdata0_q, rdata1_q;
    logic [3:0] mem_addr_q;
    logic [7:0] mem_in_q;
    logic       mem_r_q, mem_w_q;
    logic       err_q;
`ifdef MEM_ARB_RR_EN
    logic       last_q;     // port granted most recently
`endif

    logic       sel_d;
    logic       we_d;
    logic [3:0] addr_d;
    logic [7:0] wdata_d;

    // Choose which port to grant and mux its request fields.
    always_comb begin
`ifdef MEM_ARB_RR_EN
        if (req0_i && req1_i) begin
            sel_d = ~last_q;
        end else begin
            sel_d = ~req0_i;
        end
`else
        sel_d = ~req0_i;
`endif
        we_d    = sel_d ? we1_i    : we0_i;
        addr_d  = sel_d ? addr1_i  : addr0_i;
        wdata_d = sel_d ? wdata1_i : wdata0_i;
    end

    // Transaction FSM with registered strobes, acks and read data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= 4'd0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rdata0_q   <= 8'h00;
            rdata1_q   <= 8'h00;
            mem_addr_q <= 4'd0;
            mem_in_q   <= 8'h00;
            mem_r_q    <= 1'b0;
            mem_w_q    <= 1'b0;
            err_q      <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_q     <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0_i || req1_i) begin
                        gnt_q      <= sel_d;
                        we_q       <= we_d;
                        done_q     <= mem_done_i;
                        cnt_q      <= 4'd0;
                        mem_addr_q <= addr_d;
                        mem_in_q   <= wdata_d;
                        mem_r_q    <= ~we_d;
                        mem_w_q    <= we_d;
`ifdef MEM_ARB_RR_EN
                        last_q     <= sel_d;
`endif
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_r_q <= 1'b0;
                    mem_w_q <= 1'b0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (!we_q) begin
                        if (gnt_q) begin
                            rdata1_q <= mem_out_i;
                        end else begin
                            rdata0_q <= mem_out_i;
                        end
                        ack0_q  <= ~gnt_q;
                        ack1_q  <= gnt_q;
                        state_q <= RESP;
                    end else if (mem_done_i != done_q) begin
                        ack0_q  <= ~gnt_q;
                        ack1_q  <= gnt_q;
                        state_q <= RESP;
                    end else if (cnt_q == TIMEOUT_C) begin
                        err_q   <= 1'b1;
                        ack0_q  <= ~gnt_q;
                        ack1_q  <= gnt_q;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                RESP: begin
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack0_o     = ack0_q;
    assign ack1_o     = ack1_q;
    assign rdata0_o   = rdata0_q;
    assign rdata1_o   = rdata1_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_in_o   = mem_in_q;
    assign mem_r_o    = mem_r_q;
    assign mem_w_o    = mem_w_q;
    assign err_o      = err_q;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed and randomized transactions checked against
// a transaction-level model (grant order, latency arithmetic, memory image).
module tb_mem_arbiter;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1, we0, we1;
    logic [3:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       ack0, ack1;
    logic [7:0] rdata0, rdata1;
    logic [3:0] mem_addr;
    logic       mem_r, mem_w;
    logic [7:0] mem_in, mem_out;
    logic       mem_done;
    logic       busy, err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
        .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
        .ack0_o(ack0), .ack1_o(ack1), .rdata0_o(rdata0), .rdata1_o(rdata1),
        .mem_addr_o(mem_addr), .mem_r_o(mem_r), .mem_w_o(mem_w), .mem_in_o(mem_in),
        .mem_out_i(mem_out), .mem_done_i(mem_done),
        .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory environment: async read, write on strobe, done toggles wr_delay
    // cycles after the strobe edge (negative = never).
    logic [7:0] mem_arr [16];
    int wr_delay = 0;
    int tog_cnt  = 0;
    assign mem_out = mem_arr[mem_addr];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem_arr[i] <= 8'(i * 15);
            mem_done <= 1'b0;
            tog_cnt  <= 0;
        end else if (mem_w) begin
            mem_arr[mem_addr] <= mem_in;
            if (wr_delay == 0) mem_done <= ~mem_done;
            else if (wr_delay > 0) tog_cnt <= wr_delay;
        end else if (tog_cnt > 0) begin
            if (tog_cnt == 1) mem_done <= ~mem_done;
            tog_cnt <= tog_cnt - 1;
        end
    end

    // Reference model state
    logic [7:0] mm [16];
    logic [7:0] rd_m [2];
    logic       err_m;
    logic       last_m;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mm[i] = 8'(i * 15);
        rd_m[0] = 8'h00;
        rd_m[1] = 8'h00;
        err_m   = 1'b0;
        last_m  = 1'b1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    // Extra WAIT cycles a transaction spends before RESP.
    function automatic int extra(input logic w, input int dly);
        if (!w) return 0;
        if (dly < 0 || dly > TO) return TO;
        return dly;
    endfunction

    // Bookkeeping at an ack: update model, compare results, release request.
    task automatic complete(input int p, input logic w, input logic [3:0] a,
                            input logic [7:0] d, input int dly);
        if (w) begin
            mm[a] = d;
            if (dly < 0 || dly > TO) err_m = 1'b1;
        end else begin
            rd_m[p] = mm[a];
        end
        check("rdata0", 32'(rdata0), 32'(rd_m[0]));
        check("rdata1", 32'(rdata1), 32'(rd_m[1]));
        check("err", 32'(err), 32'(err_m));
        if (p == 0) req0 = 1'b0; else req1 = 1'b0;
        last_m = (p == 1);
        $display("txn port=%0d op=%s addr=%0d data=%02h rdata=%02h err=%0b cyc=%0d",
                 p, w ? "WR" : "RD", a, d, (p == 0) ? rdata0 : rdata1, err, cyc);
    endtask

    // One request pattern (one or both ports), checked cycle by cycle.
    task automatic step(input logic r0, input logic r1, input logic w0, input logic w1,
                        input logic [3:0] a0, input logic [3:0] a1,
                        input logic [7:0] d0, input logic [7:0] d1, input int dly);
        logic       wv [2];
        logic [3:0] av [2];
        logic [7:0] dv [2];
        int first, second, s1, a1c, s2, a2c, lastack;
        logic two, e0, e1, eb, er, ew;
        wv[0] = w0; wv[1] = w1; av[0] = a0; av[1] = a1; dv[0] = d0; dv[1] = d1;
        wr_delay = dly;
        we0 = w0; addr0 = a0; wdata0 = d0;
        we1 = w1; addr1 = a1; wdata1 = d1;
        req0 = r0; req1 = r1;
        two = r0 && r1;
        if (two) begin
`ifdef MEM_ARB_RR_EN
            first = last_m ? 0 : 1;
`else
            first = 0;
`endif
        end else begin
            first = r1 ? 1 : 0;
        end
        second  = 1 - first;
        s1      = cyc + 1;
        a1c     = s1 + 2 + extra(wv[first], dly);
        s2      = a1c + 2;
        a2c     = s2 + 2 + extra(wv[second], dly);
        lastack = two ? a2c : a1c;
        while (cyc < lastack + 1) begin
            @(posedge clk);
            #1;
            e0 = (first == 0 && cyc == a1c) || (two && second == 0 && cyc == a2c);
            e1 = (first == 1 && cyc == a1c) || (two && second == 1 && cyc == a2c);
            eb = (cyc >= s1 && cyc <= a1c) || (two && cyc >= s2 && cyc <= a2c);
            er = (cyc == s1 && !wv[first]) || (two && cyc == s2 && !wv[second]);
            ew = (cyc == s1 && wv[first])  || (two && cyc == s2 && wv[second]);
            check("ack0", 32'(ack0), 32'(e0));
            check("ack1", 32'(ack1), 32'(e1));
            check("busy", 32'(busy), 32'(eb));
            check("mem_r", 32'(mem_r), 32'(er));
            check("mem_w", 32'(mem_w), 32'(ew));
            if (cyc == s1) begin
                check("mem_addr", 32'(mem_addr), 32'(av[first]));
                check("mem_in", 32'(mem_in), 32'(dv[first]));
            end
            if (two && cyc == s2) begin
                check("mem_addr", 32'(mem_addr), 32'(av[second]));
                check("mem_in", 32'(mem_in), 32'(dv[second]));
            end
            if (cyc == a1c) complete(first, wv[first], av[first], dv[first], dly);
            if (two && cyc == a2c) complete(second, wv[second], av[second], dv[second], dly);
        end
    endtask

    initial begin
        int e, n, p, ep;
        rst_n = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 4'd0; addr1 = 4'd0; wdata0 = 8'h00; wdata1 = 8'h00;
        model_reset();

        // Asynchronous reset values
        #2 rst_n = 1'b0;
        #1;
        check("rst_ack0", 32'(ack0), 32'd0);
        check("rst_ack1", 32'(ack1), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_mem_r", 32'(mem_r), 32'd0);
        check("rst_mem_w", 32'(mem_w), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_in", 32'(mem_in), 32'd0);
        check("rst_rdata0", 32'(rdata0), 32'd0);
        check("rst_rdata1", 32'(rdata1), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Both ports read and hold requests across acks: grant order
        we0 = 1'b0; we1 = 1'b0; addr0 = 4'd3; addr1 = 4'd9;
        req0 = 1'b1; req1 = 1'b1;
        e = cyc;
        n = 0;
        while (n < 4 && cyc < e + 24) begin
            @(posedge clk);
            #1;
            if (ack0 || ack1) begin
                p = ack1 ? 1 : 0;
`ifdef MEM_ARB_RR_EN
                ep = last_m ? 0 : 1;
`else
                ep = 0;
`endif
                check("hold_cyc", 32'(cyc), 32'(e + 3 + 4 * n));
                check("hold_port", 32'(p), 32'(ep));
                rd_m[p] = mm[(p == 0) ? addr0 : addr1];
                check("hold_rdata0", 32'(rdata0), 32'(rd_m[0]));
                check("hold_rdata1", 32'(rdata1), 32'(rd_m[1]));
                last_m = (p == 1);
                $display("txn port=%0d op=RD held-request grant=%0d cyc=%0d", p, n, cyc);
                n++;
            end
        end
        check("hold_count", 32'(n), 32'd4);
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk);
        #1;

        // Port 0 read of addr 1 (holds 0x0F); port 1 write 0xA5 to addr 5
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 8'h00, 8'h00, 0);
        check("rd_addr1", 32'(rdata0), 32'h0F);
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd5, 8'h00, 8'hA5, 1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd5, 8'h00, 8'h00, 0);

        // Write completing exactly at the last allowed wait cycle
        step(1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 4'd0, 8'h77, 8'h00, TO);

        // Randomized traffic
        for (int k = 0; k < 40; k++) begin
            int sel;
            int dly;
            sel = int'($urandom_range(1, 3));
            dly = ($urandom_range(0, 11) == 0) ? -1 : int'($urandom_range(0, TO));
            step(sel[0], sel[1], 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
                 8'($urandom), 8'($urandom), dly);
        end

        // Write that never completes: timeout, sticky err
        step(1'b1, 1'b0, 1'b1, 1'b0, 4'd12, 4'd0, 8'h3C, 8'h00, -1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd12, 8'h00, 8'h00, 0);
        check("err_sticky", 32'(err), 32'd1);

        // Reset during WAIT of a read drops it; reissue completes
        wr_delay = 0;
        we0 = 1'b0; addr0 = 4'd7; req0 = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_ack0", 32'(ack0), 32'd0);
        check("mid_ack1", 32'(ack1), 32'd0);
        check("mid_mem_r", 32'(mem_r), 32'd0);
        check("mid_mem_w", 32'(mem_w), 32'd0);
        check("mid_err", 32'(err), 32'd0);
        check("mid_mem_addr", 32'(mem_addr), 32'd0);
        check("mid_mem_in", 32'(mem_in), 32'd0);
        check("mid_rdata0", 32'(rdata0), 32'd0);
        check("mid_rdata1", 32'(rdata1), 32'd0);
        @(posedge clk);
        #1;
        check("mid_ack0_held", 32'(ack0), 32'd0);
        rst_n = 1'b1;
        model_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd7, 4'd0, 8'h00, 8'h00, 0);
        check("reissue_rdata0", 32'(rdata0), 32'h69);

        // More randomized traffic after reset
        for (int k = 0; k < 12; k++) begin
            int sel;
            sel = int'($urandom_range(1, 3));
            step(sel[0], sel[1], 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
                 8'($urandom), 8'($urandom), int'($urandom_range(0, TO)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
